vga_timing_gen: RTL and testbench

- Parametrised successor of the fixed 800x600@72 VGA output stage.
- Generates horizontal and vertical timing from a single system clock using a pixel clock-enable, not a derived clock.
- Blanks the 12-bit input colour and exports down-sampled pixel coordinates plus frame/line strobes to the game renderer.
- Sits between the renderer (pixel_color source) and the board VGA pins.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Renderer/VGA-pin bundle for vga_timing_gen: colour in, sync, colour, coordinates and strobes out.
// master = timing generator side, slave = renderer/pin side.
interface vga_timing_gen_if #(
   parameter int unsigned COORD_W = 11
);
   logic [11:0]        pixel_color;
   logic               test_mode;
   logic [3:0]         vgaRed;
   logic [3:0]         vgaGreen;
   logic [3:0]         vgaBlue;
   logic               Hsync;
   logic               Vsync;
   logic [COORD_W-1:0] XCoord;
   logic [COORD_W-1:0] YCoord;
   logic               visible;
   logic               line_start;
   logic               frame_start;
   logic               pix_en;

   modport master (
      input  pixel_color, test_mode,
      output vgaRed, vgaGreen, vgaBlue, Hsync, Vsync,
             XCoord, YCoord, visible, line_start, frame_start, pix_en
   );

   modport slave (
      output pixel_color, test_mode,
      input  vgaRed, vgaGreen, vgaBlue, Hsync, Vsync,
             XCoord, YCoord, visible, line_start, frame_start, pix_en
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator driven by a pixel clock-enable; registered sync/colour/coord outputs.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned H_VISIBLE   = 800,
   parameter int unsigned H_FP        = 56,
   parameter int unsigned H_SYNC      = 120,
   parameter int unsigned H_BP        = 64,
   parameter int unsigned V_VISIBLE   = 600,
   parameter int unsigned V_FP        = 37,
   parameter int unsigned V_SYNC      = 6,
   parameter int unsigned V_BP        = 23,
   parameter bit          HSYNC_POL   = 1'b0,
   parameter bit          VSYNC_POL   = 1'b0,
   parameter int unsigned COORD_SHIFT = 3,
   parameter int unsigned COORD_W     = 11
) (
   input  logic               clk,
   input  logic               rst,
   vga_timing_gen_if.master   vga
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // +1 so that compare constants equal to the total still fit the counter width
   localparam int unsigned HC_W    = $clog2(H_TOTAL + 1);
   localparam int unsigned VC_W    = $clog2(V_TOTAL + 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic [HC_W-1:0]    hcount_q, hcount_d;
   logic [VC_W-1:0]    vcount_q, vcount_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic [11:0]        rgb_q, rgb_d;
   logic [COORD_W-1:0] xcoord_q, xcoord_d;
   logic [COORD_W-1:0] ycoord_q, ycoord_d;
   logic               visible_q, visible_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   logic               pix_en;
   logic               in_hsync;
   logic               in_vsync;
   logic               active;
   logic [11:0]        active_rgb;

   assign pix_en   = (div_q == DIV_W'(CLK_DIV - 1));
   assign in_hsync = (hcount_q >= HC_W'(H_VISIBLE + H_FP)) &&
                     (hcount_q <  HC_W'(H_VISIBLE + H_FP + H_SYNC));
   assign in_vsync = (vcount_q >= VC_W'(V_VISIBLE + V_FP)) &&
                     (vcount_q <  VC_W'(V_VISIBLE + V_FP + V_SYNC));
   assign active   = (hcount_q < HC_W'(H_VISIBLE)) && (vcount_q < VC_W'(V_VISIBLE));

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = H_VISIBLE / 8;
   logic [2:0] bar_idx;

   assign bar_idx    = 3'(hcount_q / HC_W'(BAR_W));
   assign active_rgb = vga.test_mode ? {{4{~bar_idx[2]}}, {4{~bar_idx[1]}}, {4{~bar_idx[0]}}}
                                     : vga.pixel_color;
`else
   assign active_rgb = vga.pixel_color;
`endif

   always_comb begin
      div_d         = pix_en ? '0 : div_q + 1'b1;
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      rgb_d         = rgb_q;
      xcoord_d      = xcoord_q;
      ycoord_d      = ycoord_q;
      visible_d     = visible_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (pix_en) begin
         if (hcount_q == HC_W'(H_TOTAL - 1)) begin
            hcount_d = '0;
            vcount_d = (vcount_q == VC_W'(V_TOTAL - 1)) ? '0 : vcount_q + 1'b1;
         end else begin
            hcount_d = hcount_q + 1'b1;
         end

         // Outputs reflect the counter value present at this enable (one enable of latency)
         hsync_d       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
         vsync_d       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
         rgb_d         = active ? active_rgb : '0;
         visible_d     = active;
         xcoord_d      = COORD_W'(32'(hcount_q) >> COORD_SHIFT);
         ycoord_d      = COORD_W'(32'(vcount_q) >> COORD_SHIFT);
         line_start_d  = (hcount_q == '0);
         frame_start_d = (hcount_q == '0) && (vcount_q == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         rgb_q         <= '0;
         xcoord_q      <= '0;
         ycoord_q      <= '0;
         visible_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         xcoord_q      <= xcoord_d;
         ycoord_q      <= ycoord_d;
         visible_q     <= visible_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.vgaRed      = rgb_q[11:8];
   assign vga.vgaGreen    = rgb_q[7:4];
   assign vga.vgaBlue     = rgb_q[3:0];
   assign vga.Hsync       = hsync_q;
   assign vga.Vsync       = vsync_q;
   assign vga.XCoord      = xcoord_q;
   assign vga.YCoord      = ycoord_q;
   assign vga.visible     = visible_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.pix_en      = pix_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised check of vga_timing_gen (two configurations) against an arithmetic pixel-index model.
// Expected outputs are derived from the number of clock edges since reset release.
module tb_vga_timing_gen;

   typedef struct {
      int unsigned div, hv, hf, hs, hb, vv, vf, vs, vb, sh, cw;
      bit          hp, vp;
   } cfg_t;

   typedef struct {
      bit          hs, vs, vis, ls, fs, load, pe;
      int unsigned h, v, x, y;
   } exp_t;

`ifdef VGA_TEST_PATTERN_EN
   localparam bit PAT_EN = 1'b1;
`else
   localparam bit PAT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.COORD_W(11)) ifa ();
   vga_timing_gen_if #(.COORD_W(4))  ifb ();

   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(64), .H_FP(8), .H_SYNC(12), .H_BP(4),
      .V_VISIBLE(20), .V_FP(3), .V_SYNC(2), .V_BP(3),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COORD_SHIFT(3), .COORD_W(11)
   ) u_dut_a (.clk(clk), .rst(rst), .vga(ifa.master));

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(32), .H_FP(4), .H_SYNC(6), .H_BP(2),
      .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_SHIFT(1), .COORD_W(4)
   ) u_dut_b (.clk(clk), .rst(rst), .vga(ifb.master));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // e = clock edges since reset release; pixel p loads on edge (p+1)*div
   function automatic exp_t model(input cfg_t c, input int unsigned e);
      exp_t        r;
      int unsigned ht, vt, p;
      r = '{default: 0};
      r.hs = !c.hp;
      r.vs = !c.vp;
      r.pe = ((e % c.div) == c.div - 1);
      if (e < c.div) return r;
      ht    = c.hv + c.hf + c.hs + c.hb;
      vt    = c.vv + c.vf + c.vs + c.vb;
      p     = e / c.div - 1;
      r.h   = p % ht;
      r.v   = (p / ht) % vt;
      r.load = ((e % c.div) == 0);
      r.hs  = (r.h >= c.hv + c.hf && r.h < c.hv + c.hf + c.hs) ? c.hp : !c.hp;
      r.vs  = (r.v >= c.vv + c.vf && r.v < c.vv + c.vf + c.vs) ? c.vp : !c.vp;
      r.vis = (r.h < c.hv) && (r.v < c.vv);
      r.x   = (r.h >> c.sh) & ((1 << c.cw) - 1);
      r.y   = (r.v >> c.sh) & ((1 << c.cw) - 1);
      r.ls  = r.load && (r.h == 0);
      r.fs  = r.load && (r.h == 0) && (r.v == 0);
      return r;
   endfunction

   function automatic logic [11:0] pixel_model(input cfg_t c, input exp_t r,
                                               input logic [11:0] pc, input logic tm);
      logic [2:0] k;
      if (!r.vis) return 12'h000;
      if (PAT_EN && tm) begin
         k = 3'(r.h / (c.hv / 8));
         return {{4{~k[2]}}, {4{~k[1]}}, {4{~k[0]}}};
      end
      return pc;
   endfunction

   task automatic compare(input string n, input exp_t r, input logic [11:0] col,
                          input logic hs, input logic vs, input logic vis, input logic ls,
                          input logic fs, input logic pe, input logic [31:0] x,
                          input logic [31:0] y, input logic [11:0] rgb);
      check({n, ".Hsync"},       32'(hs),  32'(r.hs));
      check({n, ".Vsync"},       32'(vs),  32'(r.vs));
      check({n, ".visible"},     32'(vis), 32'(r.vis));
      check({n, ".line_start"},  32'(ls),  32'(r.ls));
      check({n, ".frame_start"}, 32'(fs),  32'(r.fs));
      check({n, ".pix_en"},      32'(pe),  32'(r.pe));
      check({n, ".XCoord"},      x,        r.x);
      check({n, ".YCoord"},      y,        r.y);
      check({n, ".rgb"},         32'(rgb), 32'(col));
   endtask

   cfg_t        ca, cb;
   exp_t        ra, rb;
   logic [11:0] col_a, col_b;
   int unsigned e;
   int unsigned rst_left;

   task automatic compare_both();
      ra = model(ca, e);
      rb = model(cb, e);
      compare("A", ra, col_a, ifa.Hsync, ifa.Vsync, ifa.visible, ifa.line_start,
              ifa.frame_start, ifa.pix_en, 32'(ifa.XCoord), 32'(ifa.YCoord),
              {ifa.vgaRed, ifa.vgaGreen, ifa.vgaBlue});
      compare("B", rb, col_b, ifb.Hsync, ifb.Vsync, ifb.visible, ifb.line_start,
              ifb.frame_start, ifb.pix_en, 32'(ifb.XCoord), 32'(ifb.YCoord),
              {ifb.vgaRed, ifb.vgaGreen, ifb.vgaBlue});
   endtask

   initial begin
      ca = '{div: 2, hv: 64, hf: 8, hs: 12, hb: 4, vv: 20, vf: 3, vs: 2, vb: 3,
             sh: 3, cw: 11, hp: 1'b0, vp: 1'b0};
      cb = '{div: 1, hv: 32, hf: 4, hs: 6, hb: 2, vv: 10, vf: 2, vs: 3, vb: 1,
             sh: 1, cw: 4, hp: 1'b1, vp: 1'b1};
      ifa.pixel_color = 12'hA5C;
      ifb.pixel_color = 12'hA5C;
      ifa.test_mode   = 1'b0;
      ifb.test_mode   = 1'b0;
      e        = 0;
      col_a    = '0;
      col_b    = '0;
      rst_left = 3;

      for (int cyc = 0; cyc < 16000; cyc++) begin
         @(posedge clk);
         #1;
         if (!rst) begin
            e++;
            ra = model(ca, e);
            rb = model(cb, e);
            if (ra.load) col_a = pixel_model(ca, ra, ifa.pixel_color, ifa.test_mode);
            if (rb.load) col_b = pixel_model(cb, rb, ifb.pixel_color, ifb.test_mode);
         end else begin
            col_a = '0;
            col_b = '0;
         end
         compare_both();

         @(negedge clk);
         // Colour changes every clock so anything sampled between enables shows up
         ifa.pixel_color = (cyc < 3000) ? 12'hA5C : 12'($urandom);
         ifb.pixel_color = ifa.pixel_color;
         ifa.test_mode   = (cyc < 3000) ? 1'b0 : 1'($urandom);
         ifb.test_mode   = ifa.test_mode;

         if (rst) begin
            if (rst_left > 0) rst_left--;
            if (rst_left == 0) rst = 1'b0;
         end else if (cyc > 10000 && ($urandom_range(0, 999) == 0 || cyc == 11000)) begin
            #2;
            rst      = 1'b1;
            e        = 0;
            col_a    = '0;
            col_b    = '0;
            rst_left = $urandom_range(1, 3);
            #1;
            compare_both();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
